riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
Load/store unit that sits directly upstream of the data memory. It accepts one byte, half or word load/store request per handshake from the execute stage and converts it into word-addressed data-memory accesses with per-byte select. Misaligned accesses that cross a word boundary are split into two memory cycles. Load data is realigned and sign- or zero-extended before it is returned on a valid/ready response channel.

Parameters:
XLEN, 32, data width in bits; only 32 is supported.
DMEM_ADDR_BIT, 16, byte-address width of the data memory. Memory word address is DMEM_ADDR_BIT-2 bits.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rstn  in  1  asynchronous, active-low reset.
i_lsu_req_valid  in  1  request valid.
o_lsu_req_ready  out  1  request ready; equals (state==IDLE).
i_lsu_req_we  in  1  1 = store, 0 = load.
i_lsu_req_funct3  in  3  RV32I funct3 (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
i_lsu_req_addr  in  XLEN  byte address; bits above DMEM_ADDR_BIT-1 are ignored.
i_lsu_req_wdata  in  XLEN  store data, LSB-justified.
o_lsu_rsp_valid  out  1  response valid.
i_lsu_rsp_ready  in  1  response accepted.
o_lsu_rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
o_lsu_rsp_err  out  1  illegal funct3.
o_dmem_addr  out  DMEM_ADDR_BIT-2  memory word address.
o_dmem_data  out  XLEN  memory write data, byte-lane aligned.
o_dmem_byte_sel  out  XLEN/8  memory byte enables.
o_dmem_wr_en  out  1  memory write enable.
i_dmem_data  in  XLEN  memory read data; combinational from o_dmem_addr.

Behaviour:
- Reset (asynchronous, i_rstn=0):
  - state=IDLE; all registers cleared.
  - o_lsu_rsp_valid=0, o_lsu_rsp_rdata=0, o_lsu_rsp_err=0.
  - o_dmem_* all 0; o_lsu_req_ready=1 once reset is released.
- Reset mid-operation aborts the request and produces no response. A write already clocked into memory on an earlier edge stays written.
- States: IDLE, ACC0, ACC1, RSP.
- IDLE:
  - On valid&&ready, latch we, funct3, addr[DMEM_ADDR_BIT-1:0] and wdata.
  - Legal request: go to ACC0.
  - Illegal funct3 (011, 110, 111, or store with funct3[2]=1): go to RSP with err=1. No memory access is made.
- Access size: mask = 0001 (byte), 0011 (half), 1111 (word). off = addr[1:0]. wide = mask << off, 8 bits.
- ACC0 (one cycle):
  - o_dmem_addr = addr[DMEM_ADDR_BIT-1:2].
  - o_dmem_byte_sel = wide[3:0].
  - o_dmem_data = (wdata << 8*off)[31:0].
  - o_dmem_wr_en = we.
  - Load: capture i_dmem_data into lo.
  - Next state is ACC1 if wide[7:4]!=0, else RSP.
- ACC1 (one cycle):
  - o_dmem_addr = ACC0 address + 1, wrapping modulo 2^(DMEM_ADDR_BIT-2).
  - o_dmem_byte_sel = wide[7:4].
  - o_dmem_data = (wdata << 8*off)[63:32] of the 64-bit shift.
  - o_dmem_wr_en = we.
  - Load: capture i_dmem_data into hi.
  - Next state: RSP.
- Outside ACC0/ACC1, o_dmem_wr_en=0, o_dmem_byte_sel=0, o_dmem_addr=0, o_dmem_data=0.
- Load result: raw = ({hi,lo} >> 8*off)[31:0]; hi=0 when not split.
  - LB: sign-extend raw[7:0].
  - LH: sign-extend raw[15:0].
  - LW: raw.
  - LBU / LHU: zero-extend raw[7:0] / raw[15:0].
- RSP:
  - o_lsu_rsp_valid=1; rdata and err are registered and held stable until i_lsu_rsp_ready=1.
  - On that cycle, return to IDLE.
  - A new request is not accepted in the same cycle.
- Latency, with acceptance at edge N:
  - aligned or non-crossing access: rsp_valid from cycle N+2;
  - crossing access: rsp_valid from cycle N+3;
  - error: rsp_valid from cycle N+1.
- Throughput: at most one outstanding request.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10 -> ACC0 drives addr 4, byte_sel 1111, wr_en=1; load returns 0xDEADBEEF with err=0, 2 cycles after accept.
- SB addr 0x13, wdata 0x000000A5 -> byte_sel 1000, o_dmem_data 0xA5000000. A following LB 0x13 returns 0xFFFFFFA5; LBU 0x13 returns 0x000000A5.
- Memory word 0 = 0x44332211, word 1 = 0x88776655; LH addr 0x3 -> two accesses (byte_sel 1000 then 0001, addr 0 then 1); rdata 0x00005544, response at N+3.
- SW addr 0x2 with wdata 0xCAFEBABE -> ACC0 byte_sel 1100, data 0xBABE0000; ACC1 byte_sel 0011, data 0x0000CAFE at word 1.
- LW to the top word with off=1 -> ACC1 address wraps to 0. Hold i_lsu_rsp_ready=0 for 3 cycles -> rsp_valid and rdata held, req_ready=0 throughout.
- funct3=011 load, and store with funct3=100 -> err=1, rdata 0, no wr_en pulse, response at N+1. Assert i_rstn low during ACC1 -> outputs return to 0 immediately and no response is produced.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load/store unit: splits word-crossing accesses into two data-memory cycles,
// aligns store lanes and realigns/extends load data onto a valid/ready response.
module riscv_lsu #(
    parameter int XLEN          = 32,
    parameter int DMEM_ADDR_BIT = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_lsu_req_valid,
    output logic                     o_lsu_req_ready,
    input  logic                     i_lsu_req_we,
    input  logic [2:0]               i_lsu_req_funct3,
    input  logic [XLEN-1:0]          i_lsu_req_addr,
    input  logic [XLEN-1:0]          i_lsu_req_wdata,
    output logic                     o_lsu_rsp_valid,
    input  logic                     i_lsu_rsp_ready,
    output logic [XLEN-1:0]          o_lsu_rsp_rdata,
    output logic                     o_lsu_rsp_err,
    output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
    output logic [XLEN-1:0]          o_dmem_data,
    output logic [XLEN/8-1:0]        o_dmem_byte_sel,
    output logic                     o_dmem_wr_en,
    input  logic [XLEN-1:0]          i_dmem_data
);
    localparam int AW = DMEM_ADDR_BIT;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RSP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [3:0]        mask;
    logic [1:0]        off;
    logic [7:0]        wide;
    logic [2*XLEN-1:0] wsh;
    logic              req_illegal;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^i_lsu_req_addr[XLEN-1:AW];

    // Byte/half/word loads; anything else is rejected before a memory access.
    function automatic logic [XLEN-1:0] load_ext(input logic [2*XLEN-1:0] cat,
                                                 input logic [1:0] sh_off,
                                                 input logic [2:0] f3);
        logic [2*XLEN-1:0] sh;
        logic [XLEN-1:0]   raw;
        sh  = cat >> {sh_off, 3'b000};
        raw = sh[XLEN-1:0];
        case (f3)
            3'b000:  load_ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
            3'b001:  load_ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, raw[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, raw[15:0]};
            default: load_ext = raw;
        endcase
    endfunction

    always_comb begin
        case (f3_q[1:0])
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        off  = addr_q[1:0];
        wide = {4'b0000, mask} << off;
        wsh  = {{XLEN{1'b0}}, wdata_q} << {off, 3'b000};
    end

    assign req_illegal = (i_lsu_req_funct3 == 3'b011) || (i_lsu_req_funct3[2:1] == 2'b11) ||
                         (i_lsu_req_we && i_lsu_req_funct3[2]);

    always_comb begin
        state_d         = state_q;
        we_d            = we_q;
        f3_d            = f3_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        lo_d            = lo_q;
        rdata_d         = rdata_q;
        err_d           = err_q;
        o_dmem_addr     = '0;
        o_dmem_data     = '0;
        o_dmem_byte_sel = '0;
        o_dmem_wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_lsu_req_valid) begin
                    we_d    = i_lsu_req_we;
                    f3_d    = i_lsu_req_funct3;
                    addr_d  = i_lsu_req_addr[AW-1:0];
                    wdata_d = i_lsu_req_wdata;
                    rdata_d = '0;
                    err_d   = req_illegal;
                    state_d = req_illegal ? RSP : ACC0;
                end
            end
            ACC0: begin
                o_dmem_addr     = addr_q[AW-1:2];
                o_dmem_byte_sel = wide[3:0];
                o_dmem_data     = wsh[XLEN-1:0];
                o_dmem_wr_en    = we_q;
                if (!we_q) lo_d = i_dmem_data;
                if (wide[7:4] != 4'b0000) begin
                    state_d = ACC1;
                end else begin
                    state_d = RSP;
                    rdata_d = we_q ? '0 : load_ext({{XLEN{1'b0}}, i_dmem_data}, off, f3_q);
                end
            end
            ACC1: begin
                // Word address wraps at the top of memory.
                o_dmem_addr     = addr_q[AW-1:2] + {{(AW-3){1'b0}}, 1'b1};
                o_dmem_byte_sel = wide[7:4];
                o_dmem_data     = wsh[2*XLEN-1:XLEN];
                o_dmem_wr_en    = we_q;
                rdata_d         = we_q ? '0 : load_ext({i_dmem_data, lo_q}, off, f3_q);
                state_d         = RSP;
            end
            RSP: begin
                if (i_lsu_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign o_lsu_req_ready = (state_q == IDLE);
    assign o_lsu_rsp_valid = (state_q == RSP);
    assign o_lsu_rsp_rdata = (state_q == RSP) ? rdata_q : '0;
    assign o_lsu_rsp_err   = (state_q == RSP) ? err_q : 1'b0;

endmodule

// File: tb/tb_riscv_lsu.sv
// Randomized bench for riscv_lsu: a byte-level reference model predicts every
// memory cycle and response; one negedge process compares the DUT against it.
module tb_riscv_lsu;
    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_sel;
    logic        dmem_we;

    riscv_lsu #(.XLEN(32), .DMEM_ADDR_BIT(16)) dut (
        .i_clk(clk), .i_rstn(rst_n),
        .i_lsu_req_valid(req_valid), .o_lsu_req_ready(req_ready),
        .i_lsu_req_we(req_we), .i_lsu_req_funct3(req_f3),
        .i_lsu_req_addr(req_addr), .i_lsu_req_wdata(req_wdata),
        .o_lsu_rsp_valid(rsp_valid), .i_lsu_rsp_ready(rsp_ready),
        .o_lsu_rsp_rdata(rsp_rdata), .o_lsu_rsp_err(rsp_err),
        .o_dmem_addr(dmem_addr), .o_dmem_data(dmem_wdata),
        .o_dmem_byte_sel(dmem_sel), .o_dmem_wr_en(dmem_we),
        .i_dmem_data(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory seen by the DUT, and the model's own byte-addressed copy.
    logic [31:0] pmem [0:16383];
    logic [7:0]  rmem [0:65535];
    assign dmem_rdata = pmem[dmem_addr];
    always @(posedge clk)
        if (dmem_we)
            for (int b = 0; b < 4; b++)
                if (dmem_sel[b]) pmem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];

    typedef struct {
        logic        rv;
        logic [31:0] rd;
        logic        err;
        logic        rdy;
        logic [13:0] a;
        logic [31:0] d;
        logic [3:0]  sel;
        logic        we;
    } rec_t;
    rec_t q[$];

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle out of reset: pop the predicted cycle, or expect an idle unit.
    always @(negedge clk) begin
        rec_t e;
        if (rst_n) begin
            e = '{rv: 1'b0, rd: 32'h0, err: 1'b0, rdy: 1'b1, a: 14'h0, d: 32'h0, sel: 4'h0, we: 1'b0};
            if (q.size() > 0) e = q.pop_front();
            chk("req_ready", {31'b0, req_ready}, {31'b0, e.rdy});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e.rv});
            chk("rsp_rdata", rsp_rdata, e.rd);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            chk("dmem_addr", {18'b0, dmem_addr}, {18'b0, e.a});
            chk("dmem_data", dmem_wdata, e.d);
            chk("dmem_sel", {28'b0, dmem_sel}, {28'b0, e.sel});
            chk("dmem_we", {31'b0, dmem_we}, {31'b0, e.we});
        end
    end

    // Model output for one request: memory cycles and the response.
    int          m_n, m_sz;
    logic        m_err;
    logic [31:0] m_rd;
    logic [13:0] m_a [2];
    logic [31:0] m_d [2];
    logic [3:0]  m_sel [2];

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        logic [15:0] b;
        logic [31:0] v;
        int pos;
        m_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]);
        m_rd  = 32'h0;
        m_n   = 0;
        m_sz  = 0;
        for (int k = 0; k < 2; k++) begin
            m_a[k] = 14'h0; m_d[k] = 32'h0; m_sel[k] = 4'h0;
        end
        if (m_err) return;
        m_sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        b      = addr[15:0];
        m_a[0] = b[15:2];
        m_a[1] = b[15:2] + 14'd1;
        m_n    = (int'(b[1:0]) + m_sz > 4) ? 2 : 1;
        for (int j = 0; j < 4; j++) begin
            pos = int'(b[1:0]) + j;
            m_d[pos/4][8*(pos%4) +: 8] = wd[8*j +: 8];
            if (j < m_sz) m_sel[pos/4][pos%4] = 1'b1;
        end
        if (!we) begin
            v = 32'h0;
            for (int j = 0; j < m_sz; j++) v[8*j +: 8] = rmem[16'(b + 16'(j))];
            case (f3)
                3'd0:    m_rd = {{24{v[7]}}, v[7:0]};
                3'd1:    m_rd = {{16{v[15]}}, v[15:0]};
                3'd4:    m_rd = {24'h0, v[7:0]};
                3'd5:    m_rd = {16'h0, v[15:0]};
                default: m_rd = v;
            endcase
        end
    endtask

    task automatic commit(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        if (we && !m_err)
            for (int j = 0; j < m_sz; j++) rmem[16'(addr[15:0] + 16'(j))] = wd[8*j +: 8];
    endtask

    task automatic setw(input int idx, input logic [31:0] v);
        pmem[idx] = v;
        for (int k = 0; k < 4; k++) rmem[4*idx + k] = v[8*k +: 8];
    endtask

    // Called at posedge+1; returns at posedge+1 with the unit back in IDLE.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold);
        rec_t r;
        req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
        model(we, f3, addr, wd);
        for (int k = 0; k < m_n; k++) begin
            r = '{rv: 1'b0, rd: 32'h0, err: 1'b0, rdy: 1'b0, a: m_a[k], d: m_d[k], sel: m_sel[k], we: we};
            q.push_back(r);
        end
        for (int k = 0; k <= hold; k++) begin
            r = '{rv: 1'b1, rd: m_rd, err: m_err, rdy: 1'b0, a: 14'h0, d: 32'h0, sel: 4'h0, we: 1'b0};
            q.push_back(r);
        end
        commit(we, addr, wd);
        repeat (m_n + hold) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    initial begin
        logic [2:0]  f3s [8];
        logic [31:0] a;
        rec_t        r;
        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd0, 3'd3};
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        for (int i = 0; i < 16384; i++) setw(i, $urandom);
        #1;
        chk("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        chk("reset dmem_sel", {28'b0, dmem_sel}, 32'h0);
        chk("reset dmem_we", {31'b0, dmem_we}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed pins on the model itself.
        setw(0, 32'h44332211); setw(1, 32'h88776655);
        model(1'b0, 3'd1, 32'h3, 32'h0);
        chk("pin LH3 rdata", m_rd, 32'h00005544);
        chk("pin LH3 cycles", m_n, 2);
        chk("pin LH3 sel0", {28'b0, m_sel[0]}, 32'h8);
        chk("pin LH3 sel1", {28'b0, m_sel[1]}, 32'h1);
        model(1'b1, 3'd2, 32'h2, 32'hCAFEBABE);
        chk("pin SW2 data0", m_d[0], 32'hBABE0000);
        chk("pin SW2 data1", m_d[1], 32'h0000CAFE);
        chk("pin SW2 sel1", {28'b0, m_sel[1]}, 32'h3);
        model(1'b1, 3'd0, 32'h13, 32'h000000A5);
        chk("pin SB13 data", m_d[0], 32'hA5000000);

        // Directed scenarios.
        do_req(1'b0, 3'd1, 32'h3, 32'h0, 0);
        do_req(1'b1, 3'd2, 32'h2, 32'hCAFEBABE, 1);
        do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 0);
        do_req(1'b1, 3'd0, 32'h13, 32'h000000A5, 0);
        model(1'b0, 3'd0, 32'h13, 32'h0);
        chk("pin LB13 rdata", m_rd, 32'hFFFFFFA5);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, 0);
        do_req(1'b0, 3'd4, 32'h13, 32'h0, 0);
        do_req(1'b0, 3'd2, 32'h0000FFFD, 32'h0, 3);
        do_req(1'b0, 3'd3, 32'h20, 32'h0, 0);
        do_req(1'b1, 3'd4, 32'h24, 32'h12345678, 2);

        // Reset during the second cycle of a split load.
        req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'd2; req_addr = 32'h7; req_wdata = 32'h0;
        @(posedge clk); #1 req_valid = 1'b0;
        model(1'b0, 3'd2, 32'h7, 32'h0);
        r = '{rv: 1'b0, rd: 32'h0, err: 1'b0, rdy: 1'b0, a: m_a[0], d: m_d[0], sel: m_sel[0], we: 1'b0};
        q.push_back(r);
        @(posedge clk); #1 rst_n = 1'b0;
        q.delete();
        #1;
        chk("abort dmem_addr", {18'b0, dmem_addr}, 32'h0);
        chk("abort dmem_sel", {28'b0, dmem_sel}, 32'h0);
        chk("abort rsp_valid", {31'b0, rsp_valid}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rsp_ready = 1'b0;

        // Random traffic, concentrated on low memory and the top words.
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            if ($urandom_range(0, 9) < 7) a[15:0] = 16'($urandom_range(0, 63));
            else a[15:0] = 16'(16'hFFF8 + 16'($urandom_range(0, 7)));
            do_req(1'($urandom_range(0, 1)), f3s[$urandom_range(0, 7)], a, $urandom,
                   $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
